clk_div_ctrl: RTL and testbench

- Run-time controller for the even clock divider. It owns the divider counter, starts and stops the divided clock without runts, and accepts new half-period settings through a valid/ready handshake.
- A new setting takes effect only on a period boundary.
- Sits between the register/config logic and any logic clocked or strobed by the divided clock. The output period is always 2 x HALF input clocks.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_core.sv | 61 ++++++
 rtl/clk_div_ctrl.sv | 157 +++++++++++++++
 tb/tb_clk_div_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants for the run-time even clock divider controller.
//   - CNT_W_DEF    : default width of the counter and half-period setting
//   - HALF_ILLEGAL : half-period value that is rejected by the config port
//   - ST_*         : FSM state encoding (IDLE / RUN / DRAIN)
// -----------------------------------------------------------------------------
package clk_div_pkg;

   localparam int CNT_W_DEF    = 16;
   localparam int HALF_ILLEGAL = 0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Half-period counter plus the registered divided-clock toggle.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset
//   i_clr      clear: count <= 0, clock output <= 0 (stopped / idle)
//   i_run      count this cycle; on terminal count wrap and toggle
//   i_half     half-period in input clocks, must be >= 1
//   o_term     count is at its last value of the current phase
//   o_rise     this cycle's edge produces a 0->1 toggle
//   o_fall     this cycle's edge produces a 1->0 toggle
//   o_clk_out  divided clock (registered)
// -----------------------------------------------------------------------------
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_run,
   input  logic [CNT_W-1:0] i_half,
   output logic             o_term,
   output logic             o_rise,
   output logic             o_fall,
   output logic             o_clk_out
);

   logic [CNT_W-1:0] r_count;
   logic             r_clk_out;
   logic             w_term;

   // i_half only changes while the count is 0, so the count never runs past
   // i_half-1 and an equality compare is sufficient.
   assign w_term    = (r_count == (i_half - CNT_W'(1)));
   assign o_term    = w_term;
   assign o_rise    = i_run & w_term & ~r_clk_out;
   assign o_fall    = i_run & w_term &  r_clk_out;
   assign o_clk_out = r_clk_out;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count   <= '0;
         r_clk_out <= 1'b0;
      end else if (i_clr) begin
         r_count   <= '0;
         r_clk_out <= 1'b0;
      end else if (i_run) begin
         if (w_term) begin
            r_count   <= '0;
            r_clk_out <= ~r_clk_out;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time controller for the even clock divider. Starts and stops the
// divided clock without runt pulses and accepts new half-period settings,
// which only take effect on a period boundary (falling toggle) or in IDLE.
// Output period is always 2 x active half-period input clocks.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_en           level: 1 = run divided clock, 0 = stop cleanly
//   i_cfg_valid    new half-period offered
//   i_cfg_half     offered half-period (0 is illegal and dropped)
//   o_cfg_ready    controller can accept a setting
//   o_cfg_err      one-cycle pulse: an offered 0 was dropped
//   o_clk_out      divided clock (registered)
//   o_tick         one-cycle pulse, coincident with o_clk_out rising
//   o_busy         state is not IDLE
//   o_active_half  half-period currently in use
//   o_state        current FSM state (ST_IDLE / ST_RUN / ST_DRAIN)
// -----------------------------------------------------------------------------
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DEF_HALF = 10
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_cfg_valid,
   input  logic [CNT_W-1:0] i_cfg_half,
   output logic             o_cfg_ready,
   output logic             o_cfg_err,
   output logic             o_clk_out,
   output logic             o_tick,
   output logic             o_busy,
   output logic [CNT_W-1:0] o_active_half,
   output logic [1:0]       o_state
);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_half;
   logic [CNT_W-1:0] r_pend;
   logic             r_pend_vld;
   logic             r_cfg_err;
   logic             r_tick;

   logic [1:0]       w_nxt_state;
   logic             w_clr;
   logic             w_run;
   logic             w_term;
   logic             w_rise;
   logic             w_fall;
   logic             w_clk_out;
   logic             w_xfer;
   logic             w_legal;
   logic             w_apply;

   clk_div_core #(
      .CNT_W (CNT_W)
   ) u_core (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_clr     (w_clr),
      .i_run     (w_run),
      .i_half    (r_half),
      .o_term    (w_term),
      .o_rise    (w_rise),
      .o_fall    (w_fall),
      .o_clk_out (w_clk_out)
   );

   // FSM. RUN with EN low only stops immediately while the output is low;
   // with the output high it finishes the high phase (DRAIN) so no runt
   // pulse is produced. DRAIN keeps counting, so EN returning resumes
   // without disturbing the waveform.
   always_comb begin
      w_nxt_state = r_state;
      w_clr       = 1'b0;
      w_run       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_clr = 1'b1;
            if (i_en) w_nxt_state = ST_RUN;
         end
         ST_RUN: begin
            if (!i_en && !w_clk_out) begin
               w_clr       = 1'b1;
               w_nxt_state = ST_IDLE;
            end else begin
               w_run = 1'b1;
               if (!i_en) w_nxt_state = w_term ? ST_IDLE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            w_run = 1'b1;
            if (i_en)        w_nxt_state = ST_RUN;
            else if (w_term) w_nxt_state = ST_IDLE;
         end
         default: begin
            w_clr       = 1'b1;
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   // Handshake: a transfer happens on any rising edge where i_cfg_valid and
   // o_cfg_ready are both high; o_cfg_ready is low only while a setting is
   // waiting for a period boundary. A zero setting is consumed and reported
   // on o_cfg_err the next cycle, with no other effect.
   assign w_xfer  = i_cfg_valid & ~r_pend_vld;
   assign w_legal = (i_cfg_half != CNT_W'(HALF_ILLEGAL));

   // Pending value lands on a falling toggle or whenever the FSM is in or
   // entering IDLE (count is 0 in all of those). A transfer can never coincide
   // with an apply because ready is low while a value is pending, so a
   // setting accepted on a falling toggle waits for the following one.
   assign w_apply = r_pend_vld &
                    (w_fall | (r_state == ST_IDLE) | (w_nxt_state == ST_IDLE));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_half     <= CNT_W'(DEF_HALF);
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_tick    <= w_rise;
         r_cfg_err <= w_xfer & ~w_legal;
         if (w_apply) begin
            r_half     <= r_pend;
            r_pend_vld <= 1'b0;
         end
         if (w_xfer && w_legal) begin
            if (r_state == ST_IDLE) begin
               r_half <= i_cfg_half;
            end else begin
               r_pend     <= i_cfg_half;
               r_pend_vld <= 1'b1;
            end
         end
      end
   end

   assign o_cfg_ready   = ~r_pend_vld;
   assign o_cfg_err     = r_cfg_err;
   assign o_clk_out     = w_clk_out;
   assign o_tick        = r_tick;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_active_half = r_half;
   assign o_state       = r_state;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl: a phase-level reference model predicts
// every output each cycle; directed scenarios add waveform measurements
// (first-rise latency, periods, drain length); a random phase follows.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;
   import clk_div_pkg::*;

   localparam int CNT_W    = 16;
   localparam int DEF_HALF = 10;

   // ---------------- clock / reset / DUT ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             en;
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_half;
   logic             cfg_ready;
   logic             cfg_err;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic [CNT_W-1:0] active_half;
   logic [1:0]       state;

   clk_div_ctrl #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_en          (en),
      .i_cfg_valid   (cfg_valid),
      .i_cfg_half    (cfg_half),
      .o_cfg_ready   (cfg_ready),
      .o_cfg_err     (cfg_err),
      .o_clk_out     (clk_out),
      .o_tick        (tick),
      .o_busy        (busy),
      .o_active_half (active_half),
      .o_state       (state)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Described in waveform terms: the output sits in a phase (low or high)
   // for m_half cycles; m_age counts cycles already spent in the phase.
   logic m_busy, m_clk, m_tick, m_err, m_pvld, m_last_en;
   int   m_age, m_half, m_pend;

   task automatic model_step(input logic r, input logic e, input logic v, input int h);
      logic xfer, legal, was_busy, last_cycle;
      if (r) begin
         m_busy = 0; m_clk = 0; m_tick = 0; m_err = 0; m_pvld = 0;
         m_age = 0; m_half = DEF_HALF; m_pend = 0; m_last_en = 0;
      end else begin
         xfer     = v && !m_pvld;
         legal    = (h != 0);
         was_busy = m_busy;
         m_tick   = 0;
         m_err    = xfer && !legal;
         if (!m_busy) begin
            m_clk = 0; m_age = 0;
            if (m_pvld) begin m_half = m_pend; m_pvld = 0; end
            else if (xfer && legal) m_half = h;
            m_busy = e;
         end else if (!e && !m_clk) begin
            // stop during a low phase: immediate
            m_busy = 0; m_age = 0;
            if (m_pvld) begin m_half = m_pend; m_pvld = 0; end
         end else begin
            last_cycle = (m_age + 1 == m_half);
            if (!last_cycle) begin
               m_age++;
            end else begin
               m_age = 0;
               if (!m_clk) begin
                  m_clk = 1; m_tick = 1;
               end else begin
                  m_clk = 0;
                  if (m_pvld) begin m_half = m_pend; m_pvld = 0; end
                  if (!e) m_busy = 0;
               end
            end
         end
         if (was_busy && xfer && legal) begin m_pend = h; m_pvld = 1; end
         m_last_en = e;
      end
   endtask

   function automatic logic [1:0] model_state();
      if (!m_busy) return ST_IDLE;
      return m_last_en ? ST_RUN : ST_DRAIN;
   endfunction

   // ---------------- driver ----------------
   // Called just after a falling edge: drive inputs, advance the model over
   // the coming rising edge, compare at the next falling edge.
   task automatic cycle(input logic r, input logic e, input logic v, input logic [CNT_W-1:0] h);
      rst = r; en = e; cfg_valid = v; cfg_half = h;
      model_step(r, e, v, int'(h));
      @(negedge clk);
      chk("clk_out",     clk_out,     m_clk);
      chk("tick",        tick,        m_tick);
      chk("busy",        busy,        m_busy);
      chk("cfg_ready",   cfg_ready,   !m_pvld);
      chk("cfg_err",     cfg_err,     m_err);
      chk("active_half", active_half, m_half);
      chk("state",       state,       model_state());
   endtask

   task automatic run_until_tick(input logic e, output int n);
      n = 0;
      do begin
         cycle(1'b0, e, 1'b0, '0);
         n++;
      end while (!tick && n < 200);
      chk("tick_seen", tick, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int   n;
      int   hi;
      logic en_lvl;

      rst = 1; en = 0; cfg_valid = 0; cfg_half = '0;
      @(negedge clk);

      // reset state
      cycle(1, 0, 0, '0);
      cycle(1, 0, 0, '0);
      chk("rst_active", active_half, DEF_HALF);
      chk("rst_ready",  cfg_ready,   1);
      chk("rst_clk",    clk_out,     0);
      cycle(0, 0, 0, '0);

      // start: first rise 10 cycles after BUSY, period 20
      cycle(0, 1, 0, '0);
      chk("start_busy", busy, 1);
      n = 0;
      while (!clk_out && n < 100) begin
         n++;
         cycle(0, 1, 0, '0);
      end
      chk("first_rise", n, 10);
      chk("first_tick", tick, 1);
      run_until_tick(1, n); chk("period_10a", n, 20);
      run_until_tick(1, n); chk("period_10b", n, 20);

      // new setting 3 offered mid high phase
      repeat (4) cycle(0, 1, 0, '0);
      chk("ready_before", cfg_ready, 1);
      cycle(0, 1, 1, CNT_W'(3));
      chk("ready_pending", cfg_ready, 0);
      chk("active_still_10", active_half, 10);
      n = 0;
      while (clk_out && n < 50) begin
         n++;
         cycle(0, 1, 0, '0);
      end
      chk("active_3", active_half, 3);
      chk("ready_after", cfg_ready, 1);
      run_until_tick(1, n); chk("low_3", n, 3);
      run_until_tick(1, n); chk("period_3", n, 6);

      // EN=0 at count 4 of a high phase with half=10
      cycle(1, 0, 0, '0);
      cycle(0, 1, 0, '0);
      run_until_tick(1, n);
      repeat (4) cycle(0, 1, 0, '0);
      hi = 5;
      cycle(0, 0, 0, '0);
      chk("drain_state", state, ST_DRAIN);
      while (clk_out && hi < 50) begin
         hi++;
         cycle(0, 0, 0, '0);
      end
      chk("drain_high", hi, 10);
      chk("drain_idle", busy, 0);
      // EN=0 during a low phase: IDLE next cycle
      repeat (3) cycle(0, 1, 0, '0);
      cycle(0, 0, 0, '0);
      chk("low_stop_busy", busy, 0);
      chk("low_stop_clk",  clk_out, 0);

      // zero setting is dropped
      repeat (3) cycle(0, 1, 0, '0);
      cycle(0, 1, 1, '0);
      chk("err_pulse", cfg_err, 1);
      chk("err_ready", cfg_ready, 1);
      cycle(0, 1, 0, '0);
      chk("err_once", cfg_err, 0);
      chk("err_active", active_half, 10);
      run_until_tick(1, n);
      run_until_tick(1, n); chk("err_period", n, 20);

      // setting offered on the falling toggle (5 -> 2), then 1
      cycle(1, 0, 0, '0);
      cycle(0, 0, 1, CNT_W'(5));
      chk("idle_load", active_half, 5);
      cycle(0, 1, 0, '0);
      n = 0;
      while (!(m_busy && m_clk && (m_age + 1 == m_half)) && n < 100) begin
         n++;
         cycle(0, 1, 0, '0);
      end
      chk("pre_fall_high", clk_out, 1);
      cycle(0, 1, 1, CNT_W'(2));
      chk("fall_keep_5", active_half, 5);
      chk("fall_pending", cfg_ready, 0);
      run_until_tick(1, n); chk("keep_low_5", n, 5);
      run_until_tick(1, n); chk("switch_period", n, 7);
      run_until_tick(1, n); chk("period_2", n, 4);
      chk("active_2", active_half, 2);
      cycle(0, 1, 1, CNT_W'(1));
      run_until_tick(1, n);
      run_until_tick(1, n); chk("period_1", n, 2);
      chk("active_1", active_half, 1);

      // reset mid high phase with a setting pending
      cycle(1, 0, 0, '0);
      cycle(0, 1, 0, '0);
      run_until_tick(1, n);
      cycle(0, 1, 0, '0);
      cycle(0, 1, 1, CNT_W'(4));
      chk("mid_pending", cfg_ready, 0);
      cycle(1, 1, 0, '0);
      chk("rst_mid_clk",    clk_out,     0);
      chk("rst_mid_busy",   busy,        0);
      chk("rst_mid_active", active_half, DEF_HALF);
      chk("rst_mid_ready",  cfg_ready,   1);

      // randomized phase against the model
      en_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic             r;
         logic             v;
         logic [CNT_W-1:0] h;
         r = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 24) == 0) en_lvl = ~en_lvl;
         v = ($urandom_range(0, 6) == 0);
         case ($urandom_range(0, 4))
            0:       h = '0;
            1:       h = CNT_W'(1);
            2:       h = CNT_W'(2);
            3:       h = CNT_W'($urandom_range(3, 8));
            default: h = CNT_W'($urandom_range(1, 20));
         endcase
         cycle(r, en_lvl, v, h);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
